// File: rtl/mem_requester_pkg.sv
// Shared types and default widths for the memory requester block.
package mem_req_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_SIZE_DEF = 2;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} req_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

endpackage

// File: rtl/mem_requester_timer.sv
// Response timer: cleared before each wait, counts WAIT cycles,
// flags the minimum-wait point and the last legal cycle before timeout.
module mem_req_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_WAIT       = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic min_ok
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count;

  // Holds at the expiry value so the count can never wrap back into range.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(TIMEOUT_CYCLES - 1));
  assign min_ok  = (count >= TW'(MIN_WAIT));

endmodule

// File: rtl/mem_requester.sv
// Per-processor memory requester: one buffered command, response timeout.
// Optional MEM_REQUESTER_STATS_EN adds saturating read/write/timeout counters.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int MIN_WAIT       = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_SIZE*8-1:0] cpu_wdata,
  output logic                   cpu_resp_valid,
  output logic                   cpu_resp_err,
  output logic [DATA_SIZE*8-1:0] cpu_rdata,
  output logic                   processor_req,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_SIZE*8-1:0] mem_write_data,
  input  logic                   processor_resp,
  input  logic [DATA_SIZE*8-1:0] mem_read_data
`ifdef MEM_REQUESTER_STATS_EN
  ,
  output logic [15:0]            stat_reads,
  output logic [15:0]            stat_writes,
  output logic [15:0]            stat_timeouts
`endif
);

  req_state_t state;
  mem_op_t    cmd_op;
  logic       timer_expired;
  logic       timer_min_ok;

  mem_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MIN_WAIT       (MIN_WAIT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == IDLE || state == ISSUE),
    .enable  (state == WAIT),
    .expired (timer_expired),
    .min_ok  (timer_min_ok)
  );

  // The registered memory-side outputs double as the captured command copy.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state          <= IDLE;
      cmd_op         <= OP_READ;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      cpu_rdata      <= '0;
      processor_req  <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      addr           <= '0;
      mem_write_data <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          cpu_req_ready <= 1'b1;
          if (cpu_req_valid && cpu_req_ready) begin
            state          <= ISSUE;
            cmd_op         <= cpu_we ? OP_WRITE : OP_READ;
            cpu_req_ready  <= 1'b0;
            processor_req  <= 1'b1;
            mem_write_req  <= cpu_we;
            mem_read_req   <= !cpu_we;
            addr           <= cpu_addr;
            mem_write_data <= cpu_we ? cpu_wdata : '0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // A response on the final cycle still counts, so check it first.
          if (processor_resp && timer_min_ok) begin
            if (cmd_op == OP_READ) cpu_rdata <= mem_read_data;
            state          <= DONE;
            cpu_resp_valid <= 1'b1;
            processor_req  <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            addr           <= '0;
            mem_write_data <= '0;
          end else if (timer_expired) begin
            state          <= ERR;
            cpu_resp_valid <= 1'b1;
            cpu_resp_err   <= 1'b1;
            processor_req  <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            addr           <= '0;
            mem_write_data <= '0;
          end
        end
        DONE, ERR: begin
          state         <= IDLE;
          cpu_req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQUESTER_STATS_EN
  // Each completion state lasts exactly one cycle, so counting on the state is exact.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state == DONE && cmd_op == OP_READ && stat_reads != 16'hFFFF)
        stat_reads <= stat_reads + 16'd1;
      if (state == DONE && cmd_op == OP_WRITE && stat_writes != 16'hFFFF)
        stat_writes <= stat_writes + 16'd1;
      if (state == ERR && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester with a small behavioural memory model.
// Define MEM_REQUESTER_STATS_EN to also exercise the statistics counters.
module tb_mem_requester;

  localparam int MIN_WAIT    = 1;
  localparam int TIMEOUT     = 64;
  localparam int LAT_OK      = 3 + MIN_WAIT;
  localparam int LAT_TIMEOUT = 2 + TIMEOUT;

  localparam int M_NEXT   = 0;
  localparam int M_ALWAYS = 1;
  localparam int M_NEVER  = 2;
  localparam int M_AT     = 3;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_resp_valid;
  logic        cpu_resp_err;
  logic [15:0] cpu_rdata;
  logic        processor_req;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data;
  logic        processor_resp = 1'b0;
  logic [15:0] mem_read_data = '0;
`ifdef MEM_REQUESTER_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_timeouts;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   resp_lat = 0;
  int   mode = M_NEXT;
  int   resp_at = 0;
  int   req_cnt = 0;
  logic [15:0] last_rdata = '0;
  exp_t sb[$];

  mem_requester #(.DATA_SIZE(2), .ADDR_W(14), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_err   (cpu_resp_err),
    .cpu_rdata      (cpu_rdata),
    .processor_req  (processor_req),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .addr           (addr),
    .mem_write_data (mem_write_data),
    .processor_resp (processor_resp),
    .mem_read_data  (mem_read_data)
`ifdef MEM_REQUESTER_STATS_EN
    ,
    .stat_reads     (stat_reads),
    .stat_writes    (stat_writes),
    .stat_timeouts  (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory model: req_cnt is 1 in the ISSUE cycle, t+2 in WAIT cycle with timer t.
  always @(posedge clk) begin
    #1;
    if (processor_req) req_cnt++;
    else req_cnt = 0;
    case (mode)
      M_NEXT:   processor_resp = (req_cnt >= 2);
      M_ALWAYS: processor_resp = 1'b1;
      M_NEVER:  processor_resp = 1'b0;
      default:  processor_resp = (req_cnt == resp_at);
    endcase
  end

  task automatic apply_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    last_rdata = '0;
    @(negedge clk);
  endtask

  // Presents one command and returns after the accepting edge; then scrambles cpu_* inputs.
  task automatic do_issue(input logic we, input logic [13:0] a, input logic [15:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cpu_req_valid = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    ok = (n < 20);
    cpu_req_valid = 1'b0;
    cpu_we = 1'($urandom);
    cpu_addr = 14'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  // resp_lat is the edge (relative to acceptance) at which the core samples the pulse.
  task automatic wait_resp(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin
        found = 1'b1;
        resp_lat = cyc - acc_cyc + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [64:0] outs;
    reset_n = 1'b1;
    #13;
    outs = {cpu_req_ready, cpu_resp_valid, cpu_resp_err, cpu_rdata, processor_req,
            mem_read_req, mem_write_req, addr, mem_write_data};
    total++;
    if (outs !== '0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", cpu_req_ready); end
  endtask

  task automatic test_write();
    bit ok, found;
    exp_t e;
    mode = M_NEXT;
    do_issue(1'b1, 14'h0010, 16'hBEEF, ok);
    sb.push_back('{err: 1'b0, rdata: last_rdata, lat: LAT_OK});
    @(negedge clk);
    total++;
    if ({processor_req, mem_write_req, mem_read_req, addr, mem_write_data} !== {3'b110, 14'h0010, 16'hBEEF}) begin
      bad++;
      $display("[TB] FAIL write_issue: got req=%b wr=%b rd=%b addr=%h data=%h want 1 1 0 0010 beef",
               processor_req, mem_write_req, mem_read_req, addr, mem_write_data);
    end
    wait_resp(20, found);
    e = sb.pop_front();
    total++;
    if (!ok || !found || resp_lat != e.lat || cpu_resp_err !== e.err || cpu_rdata !== e.rdata) begin
      bad++;
      $display("[TB] FAIL write_resp: got found=%b lat=%0d err=%b rdata=%h want 1 %0d %b %h",
               found, resp_lat, cpu_resp_err, cpu_rdata, e.lat, e.err, e.rdata);
    end
    @(negedge clk);
    total++;
    if ({cpu_resp_valid, processor_req, cpu_req_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL write_after: got valid=%b req=%b ready=%b want 0 0 1", cpu_resp_valid, processor_req, cpu_req_ready);
    end
  endtask

  task automatic test_read(input int m, input logic [13:0] a, input logic [15:0] d, input string nm);
    bit ok, found;
    exp_t e;
    mode = m;
    mem_read_data = d;
    do_issue(1'b0, a, 16'hFFFF, ok);
    sb.push_back('{err: 1'b0, rdata: d, lat: LAT_OK});
    last_rdata = d;
    @(negedge clk);
    total++;
    if ({cpu_resp_valid, processor_req, mem_write_req, mem_read_req, addr, mem_write_data} !== {4'b0101, a, 16'h0000}) begin
      bad++;
      $display("[TB] FAIL %s_issue: got valid=%b req=%b wr=%b rd=%b addr=%h data=%h want 0 1 0 1 %h 0000",
               nm, cpu_resp_valid, processor_req, mem_write_req, mem_read_req, addr, mem_write_data, a);
    end
    wait_resp(20, found);
    e = sb.pop_front();
    total++;
    if (!ok || !found || resp_lat != e.lat || cpu_resp_err !== e.err || cpu_rdata !== e.rdata) begin
      bad++;
      $display("[TB] FAIL %s_resp: got found=%b lat=%0d err=%b rdata=%h want 1 %0d %b %h",
               nm, found, resp_lat, cpu_resp_err, cpu_rdata, e.lat, e.err, e.rdata);
    end
    mode = M_NEXT;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok, found;
    exp_t e;
    mode = M_NEVER;
    mem_read_data = 16'hDEAD;
    do_issue(1'b0, 14'h0200, 16'h0, ok);
    sb.push_back('{err: 1'b1, rdata: last_rdata, lat: LAT_TIMEOUT});
    wait_resp(100, found);
    e = sb.pop_front();
    total++;
    if (!ok || !found || resp_lat != e.lat || cpu_resp_err !== e.err || cpu_rdata !== e.rdata) begin
      bad++;
      $display("[TB] FAIL timeout_resp: got found=%b lat=%0d err=%b rdata=%h want 1 %0d %b %h",
               found, resp_lat, cpu_resp_err, cpu_rdata, e.lat, e.err, e.rdata);
    end
    total++;
    if ({processor_req, mem_read_req, mem_write_req} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL timeout_lines: got %b want 000", {processor_req, mem_read_req, mem_write_req});
    end
    mode = M_NEXT;
    @(negedge clk);
  endtask

  task automatic test_late_resp();
    bit ok, found;
    exp_t e;
    mode = M_AT;
    resp_at = TIMEOUT + 1;
    mem_read_data = 16'hC0DE;
    do_issue(1'b0, 14'h0300, 16'h0, ok);
    sb.push_back('{err: 1'b0, rdata: 16'hC0DE, lat: LAT_TIMEOUT});
    last_rdata = 16'hC0DE;
    wait_resp(100, found);
    e = sb.pop_front();
    total++;
    if (!ok || !found || resp_lat != e.lat || cpu_resp_err !== e.err || cpu_rdata !== e.rdata) begin
      bad++;
      $display("[TB] FAIL late_resp: got found=%b lat=%0d err=%b rdata=%h want 1 %0d %b %h",
               found, resp_lat, cpu_resp_err, cpu_rdata, e.lat, e.err, e.rdata);
    end
    mode = M_NEXT;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    mode = M_NEVER;
    do_issue(1'b1, 14'h0042, 16'h1111, ok);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    total++;
    if (!ok || {processor_req, mem_read_req, mem_write_req} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_mid_lines: got %b want 000", {processor_req, mem_read_req, mem_write_req});
    end
    @(negedge clk);
    reset_n = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) seen++;
    end
    total++;
    if (seen != 0 || cpu_req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid_after: got resp_pulses=%0d ready=%b want 0 1", seen, cpu_req_ready);
    end
    mode = M_NEXT;
  endtask

  task automatic test_back_to_back();
    bit ok, found;
    exp_t e;
    logic we;
    logic [15:0] d;
    mode = M_NEXT;
    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom);
      d = 16'($urandom);
      if (!we) begin
        mem_read_data = d;
        last_rdata = d;
      end
      do_issue(we, 14'($urandom), d, ok);
      sb.push_back('{err: 1'b0, rdata: last_rdata, lat: LAT_OK});
      wait_resp(20, found);
      e = sb.pop_front();
      total++;
      if (!ok || !found || resp_lat != e.lat || cpu_resp_err !== e.err || cpu_rdata !== e.rdata) begin
        bad++;
        $display("[TB] FAIL b2b_resp%0d: got found=%b lat=%0d err=%b rdata=%h want 1 %0d %b %h",
                 i, found, resp_lat, cpu_resp_err, cpu_rdata, e.lat, e.err, e.rdata);
      end
      @(negedge clk);
      total++;
      if (processor_req !== 1'b0 || cpu_req_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_gap%0d: got req=%b ready=%b want 0 1", i, processor_req, cpu_req_ready);
      end
    end
  endtask

`ifdef MEM_REQUESTER_STATS_EN
  task automatic test_stats();
    bit ok, found;
    int misses = 0;
    apply_reset();
    total++;
    if ({stat_reads, stat_writes, stat_timeouts} !== 48'h0) begin
      bad++;
      $display("[TB] FAIL stats_reset: got %h want 0", {stat_reads, stat_writes, stat_timeouts});
    end
    mode = M_NEXT;
    for (int i = 0; i < 5; i++) begin
      do_issue(i >= 3, 14'(i), 16'(i), ok);
      wait_resp(20, found);
      if (!ok || !found) misses++;
    end
    mode = M_NEVER;
    do_issue(1'b0, 14'h0001, 16'h0, ok);
    wait_resp(100, found);
    if (!ok || !found) misses++;
    mode = M_NEXT;
    repeat (2) @(negedge clk);
    total++;
    if (misses != 0 || stat_reads !== 16'd3 || stat_writes !== 16'd2 || stat_timeouts !== 16'd1) begin
      bad++;
      $display("[TB] FAIL stats_counts: got misses=%0d r=%0d w=%0d t=%0d want 0 3 2 1",
               misses, stat_reads, stat_writes, stat_timeouts);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting mem_requester bench");
    test_reset();
    test_write();
    test_read(M_NEXT, 14'h3FFF, 16'h1234, "read");
    test_read(M_ALWAYS, 14'h0123, 16'h5A5A, "stale");
    test_timeout();
    test_late_resp();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_REQUESTER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Processor-side initiator for the shared memory subsystem port; one instance per processor (0..3).
- Accepts single read/write commands from a core over a valid/ready interface.
- Drives that processor's request line plus mem_read_req/mem_write_req/addr/mem_write_data, waits for its response line, and returns read data, or a timeout error, to the core.
- Buffers exactly one outstanding command; an FSM with a response timeout sequences each transaction.

Parameters:
- DATA_SIZE, 2, data width in bytes (bus width DATA_SIZE*8).
- ADDR_W, 14, memory address width.
- MIN_WAIT, 1, cycles held in WAIT before processor_resp is honoured (masks a stale response from a previous transaction).
- TIMEOUT_CYCLES, 64, cycles in WAIT without response before an error completion; must be > MIN_WAIT.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-high reset (asserted = 1).
- cpu_req_valid  in  1  core command valid.
- cpu_req_ready  out  1  block can accept a command.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  command address.
- cpu_wdata  in  DATA_SIZE*8  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_err  out  1  completion was a timeout; valid with cpu_resp_valid.
- cpu_rdata  out  DATA_SIZE*8  read data; valid with cpu_resp_valid for a read without error.
- processor_req  out  1  this processor's request line to memory.
- mem_read_req  out  1  read strobe to memory.
- mem_write_req  out  1  write strobe to memory.
- addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_SIZE*8  memory write data.
- processor_resp  in  1  this processor's response line from memory.
- mem_read_data  in  DATA_SIZE*8  memory read data.

Behaviour:
- Reset values (applied asynchronously while reset_n = 1): all outputs 0, FSM in IDLE, timer 0, command register cleared.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - cpu_req_ready = 1; all other outputs are 0.
  - When cpu_req_valid = 1, capture cpu_we/cpu_addr/cpu_wdata and go to ISSUE.
- ISSUE (1 cycle):
  - cpu_req_ready = 0.
  - Drive processor_req = 1, exactly one of mem_write_req (we = 1) or mem_read_req (we = 0), addr, and mem_write_data (0 for reads).
  - Clear the timer; go to WAIT.
- WAIT:
  - Memory-side outputs are held unchanged; the timer increments each cycle.
  - When processor_resp = 1 and timer >= MIN_WAIT: register mem_read_data into cpu_rdata (reads only; cpu_rdata is held for writes) and go to DONE.
  - Otherwise, when timer reaches TIMEOUT_CYCLES-1, go to ERR.
  - If response and timeout fall on the same cycle, the response wins.
- DONE (1 cycle):
  - All memory-side outputs drop to 0; cpu_resp_valid = 1, cpu_resp_err = 0; go to IDLE.
- ERR (1 cycle):
  - All memory-side outputs drop to 0; cpu_resp_valid = 1, cpu_resp_err = 1, cpu_rdata unchanged; go to IDLE.
- Latency:
  - Accept edge to cpu_resp_valid is 3 + MIN_WAIT cycles minimum.
  - Back-to-back commands are separated by at least one IDLE cycle, during which processor_req = 0.
- Asserting reset_n mid-transaction aborts it: the request lines drop immediately and no completion is produced.
- The core may change cpu_* inputs freely after acceptance; the block uses only the captured copy.
- No retry; arbitration is the memory subsystem's concern. The requester simply holds the request until it is answered or times out.

Optional Feature:
- Macro MEM_REQUESTER_STATS_EN.
- When defined:
  - Adds three 16-bit outputs: stat_reads, stat_writes, stat_timeouts.
  - stat_reads / stat_writes increment on each DONE of the respective type; stat_timeouts increments on each ERR.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_req_pkg holds:
  - req_state_t enum {IDLE, ISSUE, WAIT, DONE, ERR};
  - typedef mem_op_t {OP_READ, OP_WRITE};
  - localparams ADDR_W_DEF = 14 and DATA_SIZE_DEF = 2.
- One sub-module, mem_req_timer: clear/enable counter with a `expired` output at TIMEOUT_CYCLES-1 and a `min_ok` output at >= MIN_WAIT.

Test Plan:
- Write: cpu_we = 1, addr = 14'h0010, wdata = 16'hBEEF; memory model asserts resp 1 cycle after seeing req -> mem_write_req = 1, addr = 0x0010, mem_write_data = 0xBEEF; cpu_resp_valid pulses once with err = 0, 4 cycles after acceptance.
- Read: cpu_we = 0, addr = 14'h3FFF; model returns 16'h1234 with resp -> mem_read_req = 1, mem_write_data = 0; cpu_rdata = 0x1234, err = 0.
- Stale response: hold processor_resp = 1 continuously, then issue a read -> resp ignored in the first WAIT cycle; completion at the earliest legal cycle (timer = MIN_WAIT), not in ISSUE.
- Timeout: model never responds -> exactly TIMEOUT_CYCLES = 64 WAIT cycles, then cpu_resp_valid = 1 with cpu_resp_err = 1 and cpu_rdata unchanged; req lines return to 0. Response arriving on cycle 63 -> normal DONE.
- Reset mid-WAIT: assert reset_n = 1 asynchronously between clock edges -> processor_req/mem_*_req go 0 immediately, no cpu_resp_valid, cpu_req_ready = 1 after release.
- Stats (MEM_REQUESTER_STATS_EN): 3 reads, 2 writes, 1 timeout -> stat_reads = 3, stat_writes = 2, stat_timeouts = 1.
